// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staged reset sequencer with soft reset; optional watchdog under RST_SEQ_WDOG_EN
module rst_seq_ctrl #(
    parameter int N_STAGES        = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 4,
    parameter int SOFT_MIN_CYCLES = 8,
    parameter int CNT_W           = 8,
    parameter int WDOG_TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soft_rst_req,
    input  logic                wdog_kick,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                ready,
    output logic                busy,
    output logic [CNT_W-1:0]    soft_cnt,
    output logic [2:0]          seq_state,
    output logic                wdog_fired
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_SOFT    = 3'd4
    } state_t;

    // One shared cycle counter covers HOLD, the inter-stage gap and the SOFT minimum
    localparam int CMAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CMAX   = (CMAX_A > SOFT_MIN_CYCLES) ? CMAX_A : SOFT_MIN_CYCLES;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int IW     = $clog2(N_STAGES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_MIN_CYCLES - 1);
    localparam logic [IW-1:0] ALL_REL   = IW'(N_STAGES);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;          // number of stages already released
    logic            soft_origin;  // current sequence was started by a soft reset
    logic            wdog_trip;

    assign seq_state = state;

`ifdef RST_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_TIMEOUT + 1);
    logic [WW-1:0] wcnt;

    assign wdog_trip = (state == S_RUN) && !wdog_kick && (wcnt == WW'(WDOG_TIMEOUT - 1));

    // Watchdog: counts RUN edges since RUN entry or last kick; cleared elsewhere
    always_ff @(posedge clk) begin
        if (!rst || state != S_RUN || wdog_kick || wdog_trip) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
        if (!rst) begin
            wdog_fired <= 1'b0;
        end else begin
            wdog_fired <= wdog_trip;
        end
    end
`else
    localparam int unused_wdog_timeout = WDOG_TIMEOUT;
    logic unused_kick;
    assign unused_kick = wdog_kick;
    assign wdog_trip   = 1'b0;
    assign wdog_fired  = 1'b0;
`endif

    // Sequencer FSM: hard reset, hold, ordered release, run, soft reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RESET;
            stage_rst_n <= '0;
            ready       <= 1'b0;
            busy        <= 1'b1;
            soft_cnt    <= '0;
            cnt         <= '0;
            idx         <= '0;
            soft_origin <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state       <= S_HOLD;
                    cnt         <= '0;
                    idx         <= '0;
                    stage_rst_n <= '0;
                    ready       <= 1'b0;
                    busy        <= 1'b1;
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state       <= S_RELEASE;
                        stage_rst_n <= N_STAGES'(1);
                        idx         <= IW'(1);
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (idx == ALL_REL) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (soft_origin) begin
                            soft_origin <= 1'b0;
                            if (soft_cnt != '1) begin
                                soft_cnt <= soft_cnt + 1'b1;
                            end
                        end
                    end else if (cnt == GAP_LAST) begin
                        stage_rst_n <= stage_rst_n | (N_STAGES'(1) << idx);
                        idx         <= idx + 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (soft_rst_req || wdog_trip) begin
                        state       <= S_SOFT;
                        stage_rst_n <= '0;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        soft_origin <= 1'b1;
                    end
                end
                S_SOFT: begin
                    // Counter saturates at the minimum so a long request cannot wrap it
                    if (cnt >= SOFT_LAST && !soft_rst_req) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                        idx   <= '0;
                    end else if (cnt < SOFT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= S_RESET;
                    stage_rst_n <= '0;
                    ready       <= 1'b0;
                    busy        <= 1'b1;
                    cnt         <= '0;
                    idx         <= '0;
                    soft_origin <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - self-checking bench for rst_seq_ctrl (default and small saturating instance)
module tb_rst_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req0, req1, kick;

    logic [2:0] stg0;
    logic       rdy0, bsy0, wdf0;
    logic [7:0] cnt0;
    logic [2:0] st0;

    logic [1:0] stg1;
    logic       rdy1, bsy1, wdf1;
    logic [1:0] cnt1;
    logic [2:0] st1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl u_dut (
        .clk(clk), .rst(rst), .soft_rst_req(req0), .wdog_kick(kick),
        .stage_rst_n(stg0), .ready(rdy0), .busy(bsy0), .soft_cnt(cnt0),
        .seq_state(st0), .wdog_fired(wdf0)
    );

    rst_seq_ctrl #(
        .N_STAGES(2), .HOLD_CYCLES(3), .STAGE_GAP(2), .SOFT_MIN_CYCLES(2), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .soft_rst_req(req1), .wdog_kick(kick),
        .stage_rst_n(stg1), .ready(rdy1), .busy(bsy1), .soft_cnt(cnt1),
        .seq_state(st1), .wdog_fired(wdf1)
    );

    // Model parameters per instance
    int p_n[2]    = '{3, 2};
    int p_h[2]    = '{16, 3};
    int p_g[2]    = '{4, 2};
    int p_min[2]  = '{8, 2};
    int p_cmax[2] = '{255, 3};

    // Model: phase 0=reset 1=sequencing 2=run 3=soft; t = edges since sequence start
    int  ph[2], mt[2], ms[2], mc[2], mf[2];
    bit  mvalid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic r;
            r = (k == 0) ? req0 : req1;
            if (!rst) begin
                ph[k] = 0; mc[k] = 0; mf[k] = 0;
            end else begin
                case (ph[k])
                    0: begin ph[k] = 1; mt[k] = 0; end
                    1: begin
                        mt[k]++;
                        if (mt[k] >= p_h[k] + (p_n[k] - 1) * p_g[k] + 1) begin
                            ph[k] = 2;
                            if (mf[k] != 0) begin
                                mf[k] = 0;
                                if (mc[k] < p_cmax[k]) mc[k]++;
                            end
                        end
                    end
                    2: if (r) begin ph[k] = 3; ms[k] = 0; mf[k] = 1; end
                    default: begin
                        ms[k]++;
                        if (ms[k] >= p_min[k] && !r) begin ph[k] = 1; mt[k] = 0; end
                    end
                endcase
            end
        end
        if (!rst) mvalid = 1'b1;
    end

    function automatic int exp_stage(input int k);
        int v = 0;
        if (ph[k] == 2) v = (1 << p_n[k]) - 1;
        else if (ph[k] == 1)
            for (int i = 0; i < p_n[k]; i++)
                if (mt[k] >= p_h[k] + i * p_g[k]) v |= (1 << i);
        return v;
    endfunction

    function automatic int exp_state(input int k);
        case (ph[k])
            0: return 0;
            1: return (mt[k] < p_h[k]) ? 1 : 2;
            2: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_stage0", 32'(stg0), exp_stage(0));
            chk("m_ready0", 32'(rdy0), (ph[0] == 2) ? 1 : 0);
            chk("m_busy0",  32'(bsy0), (ph[0] == 2) ? 0 : 1);
            chk("m_cnt0",   32'(cnt0), mc[0]);
            chk("m_state0", 32'(st0),  exp_state(0));
            chk("m_wdog0",  32'(wdf0), 0);
            chk("m_stage1", 32'(stg1), exp_stage(1));
            chk("m_ready1", 32'(rdy1), (ph[1] == 2) ? 1 : 0);
            chk("m_busy1",  32'(bsy1), (ph[1] == 2) ? 0 : 1);
            chk("m_cnt1",   32'(cnt1), mc[1]);
            chk("m_state1", 32'(st1),  exp_state(1));
            chk("m_wdog1",  32'(wdf1), 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input int k, input int budget);
        int i = 0;
        while (((k == 0) ? rdy0 : rdy1) !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (((k == 0) ? rdy0 : rdy1) !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready%0d actual=timeout required=ready within %0d cycles", k, budget);
        end
    endtask

    task automatic wait_state0(input logic [2:0] s, input int budget);
        int i = 0;
        while (st0 !== s && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (st0 !== s) begin
            failures++;
            $display("FAIL wait_state actual=%0d required=%0d", st0, s);
        end
    endtask

    task automatic soft_pulse0();
        req0 = 1'b1; step(1); req0 = 1'b0;
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; kick = 1'b0;
        step(10);
        chk("rst_stage", 32'(stg0), 0);
        chk("rst_ready", 32'(rdy0), 0);
        chk("rst_busy",  32'(bsy0), 1);
        chk("rst_state", 32'(st0),  0);
        chk("rst_cnt",   32'(cnt0), 0);

        // Hard reset release: next edge is E0
        rst = 1'b1;
        step(16);
        chk("hard_e15_stage", 32'(stg0), 0);
        chk("hard_e15_state", 32'(st0), 1);
        step(1);
        chk("hard_e16_stage", 32'(stg0), 1);
        chk("hard_e16_state", 32'(st0), 2);
        step(4);
        chk("hard_e20_stage", 32'(stg0), 3);
        step(4);
        chk("hard_e24_stage", 32'(stg0), 7);
        chk("hard_e24_ready", 32'(rdy0), 0);
        step(1);
        chk("hard_e25_ready", 32'(rdy0), 1);
        chk("hard_e25_state", 32'(st0), 3);
        chk("hard_e25_busy",  32'(bsy0), 0);

        // Single-cycle soft reset
        soft_pulse0();
        chk("soft_entry_state", 32'(st0), 4);
        chk("soft_entry_stage", 32'(stg0), 0);
        step(7);
        chk("soft_s7_state", 32'(st0), 4);
        step(1);
        chk("soft_exit_state", 32'(st0), 1);
        step(16);
        chk("soft_x16_stage", 32'(stg0), 1);
        step(9);
        chk("soft_x25_ready", 32'(rdy0), 1);
        chk("soft_x25_cnt",   32'(cnt0), 1);

        // Long soft request, then a pulse during HOLD that must be ignored
        req0 = 1'b1;
        step(20);
        chk("long_s19_state", 32'(st0), 4);
        req0 = 1'b0;
        step(1);
        chk("long_exit_state", 32'(st0), 1);
        soft_pulse0();
        chk("hold_pulse_state", 32'(st0), 1);
        wait_ready(0, 40);
        chk("long_cnt", 32'(cnt0), 2);

        // Request held through RELEASE is honoured on the first RUN edge
        soft_pulse0();
        wait_state0(3'd2, 40);
        req0 = 1'b1;
        wait_ready(0, 20);
        chk("held_run_state", 32'(st0), 3);
        step(1);
        chk("held_soft_state", 32'(st0), 4);
        chk("held_cnt", 32'(cnt0), 3);
        req0 = 1'b0;
        wait_ready(0, 60);
        chk("held_cnt_after", 32'(cnt0), 4);

        // Mid-sequence abort at X+18
        soft_pulse0();
        wait_state0(3'd1, 20);
        step(17);
        chk("abort_x17_stage", 32'(stg0), 1);
        rst = 1'b0;
        step(1);
        chk("abort_state", 32'(st0), 0);
        chk("abort_stage", 32'(stg0), 0);
        chk("abort_cnt",   32'(cnt0), 0);
        rst = 1'b1;
        step(16);
        chk("abort_e15_state", 32'(st0), 1);
        step(10);
        chk("abort_e25_ready", 32'(rdy0), 1);
        chk("abort_e25_cnt",   32'(cnt0), 0);

        // Saturation on the 2-bit counter instance
        wait_ready(1, 20);
        for (int j = 0; j < 5; j++) begin
            req1 = 1'b1; step(1); req1 = 1'b0;
            chk("sat_soft_state", 32'(st1), 4);
            wait_ready(1, 30);
            chk("sat_cnt", 32'(cnt1), 32'(sat_exp[j]));
        end

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
